sram_access_seq: RTL and testbench
==================================

Name: sram_access_seq

Overview:
- Request sequencer that sits directly upstream of the byte-laned 16-bit work RAM and drives its cs/oe/wr/odd/even/addr/din inputs.
- Converts CPU-side byte and word accesses at byte addresses into one or two RAM cycles.
- Splits misaligned words into two single-lane accesses.
- Returns read data and a one-cycle acknowledge.

Parameters:
- ADDR_WIDTH, 16, RAM word-address width; the CPU byte address is ADDR_WIDTH+1 bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  1  access request, level; held by the master until ack
- we  in  1  1 = write, 0 = read; sampled with req
- word  in  1  1 = 16-bit access, 0 = byte access
- cpu_addr  in  ADDR_WIDTH+1  byte address; bit0 = lane (0 even/low, 1 odd/high)
- wdata  in  16  write data; byte access uses wdata[7:0]
- ack  out  1  one-cycle completion pulse
- rdata  out  16  read result, valid while ack=1; byte read zero-extended
- mem_cs  out  1  RAM chip select
- mem_oe  out  1  RAM output enable
- mem_wr  out  1  RAM write strobe
- mem_even  out  1  low-lane select
- mem_odd  out  1  high-lane select
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_din  out  16  RAM write data; lane writes carry the byte in [7:0]
- mem_q  in  16  RAM read data; valid the cycle after a read is presented while cs&oe stay high; lane reads return the byte in [7:0]

Behaviour:
- Reset (asynchronous, active-low): state IDLE; ack, rdata, every mem_* output = 0. Reset mid-access aborts it with no ack; a partially completed misaligned write leaves only its first byte written.
- All outputs are registered.
- IDLE: if req=1, latch we, word, cpu_addr, wdata and go to ISSUE1. req is ignored in every other state.
- Access classification:
  - byte: one access, lane = addr[0], word address = addr[ADDR_WIDTH:1].
  - aligned word (addr[0]=0): one full-width access with even=odd=0.
  - misaligned word (addr[0]=1): two accesses: odd lane at word address W carries the low byte; even lane at W+1 carries the high byte.
  - W+1 wraps modulo 2^ADDR_WIDTH; the top word wraps to 0.
- ISSUE1: drive the first access.
  - Write: mem_cs=1, mem_wr=1, mem_oe=0.
  - Read: mem_cs=1, mem_oe=1, mem_wr=0.
  - Next state: write → ISSUE2 if split, else DONE; read → WAIT1.
- WAIT1: hold cs/oe/addr/lane; capture mem_q at the end of the cycle.
  - Byte or aligned word: rdata = mem_q (byte: {8'h00, mem_q[7:0]}); go to DONE.
  - Split: rdata[7:0] = mem_q[7:0]; go to ISSUE2.
- ISSUE2: second access (even lane, W+1). Write data = wdata[15:8]. Write → DONE; read → WAIT2.
- WAIT2: rdata[15:8] = mem_q[7:0]; go to DONE.
- DONE: all mem_* = 0, ack=1 for exactly one cycle, then IDLE.
- rdata holds its value until the next read capture; writes leave it unchanged.
- Latency from the req-sampling edge to ack high:
  - aligned or byte write: 2 cycles
  - split write: 3 cycles
  - aligned or byte read: 3 cycles
  - split read: 5 cycles
- Back-to-back throughput: with req held high, a new request is accepted on the IDLE cycle following DONE.
- mem_din:
  - full-width write: wdata
  - byte write: {8'h00, wdata[7:0]}
  - split write: {8'h00, wdata[7:0]} then {8'h00, wdata[15:8]}
- mem_even and mem_odd are never both 1. mem_wr and mem_oe are never both 1. All mem_* are 0 outside ISSUE/WAIT states.

Test Plan:
- Aligned word: write 16'hBEEF at byte addr 0x0010, then read 0x0010 → mem_addr=0x0008, even=odd=0; ack 2 cycles after accept for the write and 3 cycles after accept for the read; rdata=16'hBEEF.
- Byte lanes: write 8'h12 at 0x0021 and 8'h34 at 0x0020, then word-read 0x0020 → rdata=16'h1234; byte-read 0x0021 → rdata=16'h0012, with mem_odd=1 during that access.
- Misaligned word: write 16'hA55A at 0x0031 → odd-lane write of 8'h5A at word 0x18, then even-lane write of 8'hA5 at word 0x19; ack at cycle 3. Read 0x0031 → rdata=16'hA55A, ack at cycle 5.
- Wrap: word write 16'hC3D4 at byte addr 0x1FFFF (ADDR_WIDTH=16) → second access at mem_addr=0x0000 (even lane), 8'hC3; a read of 0x1FFFF returns 16'hC3D4.
- Reset mid-op: assert reset_n=0 during WAIT1 of a split read → all outputs 0 immediately, no ack. After release, state is IDLE, and a fresh byte read returns correct data.
- Hold/ignore: keep req=1 across DONE → exactly one ack per access; the second request starts in the IDLE cycle after ack. cpu_addr changed mid-access does not alter the in-flight mem_addr.

Source files
------------

// File: rtl/sram_access_seq_if.sv
// sram_access_seq_if: CPU request/ack bus plus byte-laned RAM port of the access sequencer
interface sram_access_seq_if #(parameter int ADDR_WIDTH = 16);
  logic                  req;
  logic                  we;
  logic                  word;
  logic [ADDR_WIDTH:0]   cpu_addr;
  logic [15:0]           wdata;
  logic                  ack;
  logic [15:0]           rdata;
  logic                  mem_cs;
  logic                  mem_oe;
  logic                  mem_wr;
  logic                  mem_even;
  logic                  mem_odd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_din;
  logic [15:0]           mem_q;
  modport master (
    output req, we, word, cpu_addr, wdata, mem_q,
    input  ack, rdata, mem_cs, mem_oe, mem_wr, mem_even, mem_odd, mem_addr, mem_din
  );
  modport slave (
    input  req, we, word, cpu_addr, wdata, mem_q,
    output ack, rdata, mem_cs, mem_oe, mem_wr, mem_even, mem_odd, mem_addr, mem_din
  );
endinterface

// File: rtl/sram_access_seq.sv
// sram_access_seq: turns CPU byte/word accesses into one or two byte-laned RAM cycles
module sram_access_seq #(
  parameter int ADDR_WIDTH = 16
) (
  input logic           clk,
  input logic           reset_n,
  sram_access_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE} state_t;
  state_t state, state_nx;
  logic                  we_q, word_q;
  logic [ADDR_WIDTH:0]   addr_q;
  logic [15:0]           wdata_q;
  logic                  split, in_first, in_second, active;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr1;
  logic                  cs_d, oe_d, wr_d, even_d, odd_d, ack_d, cap_lo_d, cap_hi_d;
  logic                  cap_lo, cap_hi;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [15:0]           din_d;
  assign split   = word_q & addr_q[0];
  assign w_addr  = addr_q[ADDR_WIDTH:1];
  assign w_addr1 = w_addr + ADDR_WIDTH'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && bus.req) begin
      we_q    <= bus.we;
      word_q  <= bus.word;
      addr_q  <= bus.cpu_addr;
      wdata_q <= bus.wdata;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.req ? ISSUE1 : IDLE;
      ISSUE1:  state_nx = !we_q ? WAIT1 : (split ? ISSUE2 : DONE);
      WAIT1:   state_nx = split ? ISSUE2 : DONE;
      ISSUE2:  state_nx = we_q ? DONE : WAIT2;
      WAIT2:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs are registered from the current state, so the RAM sees each phase one cycle after the FSM enters it
  always_comb begin
    in_first  = state == ISSUE1 || state == WAIT1;
    in_second = state == ISSUE2 || state == WAIT2;
    active    = in_first || in_second;
    cs_d      = active;
    wr_d      = active && we_q;
    oe_d      = active && !we_q;
    odd_d     = in_first && addr_q[0];
    even_d    = in_second || (in_first && !word_q && !addr_q[0]);
    addr_d    = in_second ? w_addr1 : (in_first ? w_addr : '0);
    din_d     = !wr_d ? 16'h0000 :
                in_second ? {8'h00, wdata_q[15:8]} :
                (word_q && !addr_q[0]) ? wdata_q : {8'h00, wdata_q[7:0]};
    ack_d     = state == DONE;
    cap_lo_d  = state == WAIT1;
    cap_hi_d  = state == WAIT2;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.mem_cs   <= 1'b0;
      bus.mem_oe   <= 1'b0;
      bus.mem_wr   <= 1'b0;
      bus.mem_even <= 1'b0;
      bus.mem_odd  <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.ack      <= 1'b0;
      bus.rdata    <= '0;
      cap_lo       <= 1'b0;
      cap_hi       <= 1'b0;
    end else begin
      bus.mem_cs   <= cs_d;
      bus.mem_oe   <= oe_d;
      bus.mem_wr   <= wr_d;
      bus.mem_even <= even_d;
      bus.mem_odd  <= odd_d;
      bus.mem_addr <= addr_d;
      bus.mem_din  <= din_d;
      bus.ack      <= ack_d;
      cap_lo       <= cap_lo_d;
      cap_hi       <= cap_hi_d;
      if (cap_lo)
        bus.rdata <= split ? {bus.rdata[15:8], bus.mem_q[7:0]} :
                     word_q ? bus.mem_q : {8'h00, bus.mem_q[7:0]};
      else if (cap_hi)
        bus.rdata[15:8] <= bus.mem_q[7:0];
    end
endmodule

// File: tb/tb_sram_access_seq.sv
// tb_sram_access_seq: directed and random accesses checked against a byte-array model of CPU memory
module tb_sram_access_seq;
  localparam int AW = 16;
  localparam int NB = 1 << (AW + 1);
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] last_rdata = 16'h0000;
  logic [15:0] ram [0:(1<<AW)-1];
  logic [7:0]  bmem [0:NB-1];
  always #5 clk = ~clk;
  sram_access_seq_if #(.ADDR_WIDTH(AW)) bus ();
  sram_access_seq #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  // Byte-laned RAM: data valid the cycle after a read is presented, junk otherwise
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_wr) begin
      if (bus.mem_even)     ram[bus.mem_addr][7:0]  <= bus.mem_din[7:0];
      else if (bus.mem_odd) ram[bus.mem_addr][15:8] <= bus.mem_din[7:0];
      else                  ram[bus.mem_addr]       <= bus.mem_din;
    end
    bus.mem_q <= (bus.mem_cs && bus.mem_oe) ?
                 (bus.mem_even ? {8'h00, ram[bus.mem_addr][7:0]} :
                  bus.mem_odd  ? {8'h00, ram[bus.mem_addr][15:8]} : ram[bus.mem_addr]) :
                 16'($urandom);
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic we, input logic word, input logic [AW:0] a,
                        input logic [15:0] wd, input bit keep);
    logic [AW:0]   a1;
    logic          split;
    int            exp_lat, sec, k;
    logic [AW+4:0] snap [0:20];
    logic [15:0]   dsnap [0:20];
    logic [15:0]   exp_rd;
    bit            bad;
    a1      = a + 1'b1;
    split   = word & a[0];
    exp_lat = we ? (split ? 3 : 2) : (split ? 5 : 3);
    sec     = we ? 2 : 3;
    bad     = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.word = word; bus.cpu_addr = a; bus.wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_addr = 17'($urandom); bus.wdata = 16'($urandom);
    bus.we = 1'($urandom); bus.word = 1'($urandom);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      snap[k]  = {bus.mem_cs, bus.mem_wr, bus.mem_oe, bus.mem_even, bus.mem_odd, bus.mem_addr};
      dsnap[k] = bus.mem_din;
      if ((bus.mem_even && bus.mem_odd) || (bus.mem_wr && bus.mem_oe)) bad = 1'b1;
      if (bus.ack) break;
    end
    check("latency", 64'(k), 64'(exp_lat));
    check("first_access", 64'(snap[1]), 64'({1'b1, we, !we, !word && !a[0], a[0], a[AW:1]}));
    if (we) check("first_din", 64'(dsnap[1]), 64'((word && !a[0]) ? wd : {8'h00, wd[7:0]}));
    if (split) check("second_access", 64'(snap[sec]), 64'({1'b1, we, !we, 1'b1, 1'b0, a1[AW:1]}));
    if (split && we) check("second_din", 64'(dsnap[sec]), 64'({8'h00, wd[15:8]}));
    check("lane_exclusive", 64'(bad), 64'(0));
    check("mem_idle_at_ack", {bus.mem_cs, bus.mem_oe, bus.mem_wr, bus.mem_even, bus.mem_odd,
                              bus.mem_addr, bus.mem_din}, 64'(0));
    if (we) begin
      bmem[a] = wd[7:0];
      if (word) bmem[a1] = wd[15:8];
      check("rdata_hold", 64'(bus.rdata), 64'(last_rdata));
    end else begin
      exp_rd = word ? {bmem[a1], bmem[a]} : {8'h00, bmem[a]};
      check("rdata", 64'(bus.rdata), 64'(exp_rd));
      last_rdata = exp_rd;
    end
    if (!keep) begin
      bus.req = 1'b0;
      @(posedge clk); #1;
      check("ack_one_cycle", 64'(bus.ack), 64'(0));
    end
  endtask
  initial begin
    bit seen;
    logic [AW:0] ra;
    bus.req = 1'b0; bus.we = 1'b0; bus.word = 1'b0; bus.cpu_addr = '0; bus.wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 16'h0000;
    for (int i = 0; i < NB; i++) bmem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.ack, bus.rdata, bus.mem_cs, bus.mem_oe, bus.mem_wr, bus.mem_even,
                          bus.mem_odd, bus.mem_addr, bus.mem_din}, 64'(0));
    @(negedge clk); reset_n = 1'b1;
    access(1'b1, 1'b1, 17'h00010, 16'hBEEF, 1'b0);
    access(1'b0, 1'b1, 17'h00010, 16'h0000, 1'b0);
    check("plan_aligned", 64'(bus.rdata), 64'(16'hBEEF));
    access(1'b1, 1'b0, 17'h00021, 16'hFF12, 1'b0);
    access(1'b1, 1'b0, 17'h00020, 16'hEE34, 1'b0);
    access(1'b0, 1'b1, 17'h00020, 16'h0000, 1'b0);
    check("plan_lanes", 64'(bus.rdata), 64'(16'h1234));
    access(1'b0, 1'b0, 17'h00021, 16'h0000, 1'b0);
    check("plan_byte_read", 64'(bus.rdata), 64'(16'h0012));
    access(1'b1, 1'b1, 17'h00031, 16'hA55A, 1'b0);
    access(1'b0, 1'b1, 17'h00031, 16'h0000, 1'b0);
    check("plan_misaligned", 64'(bus.rdata), 64'(16'hA55A));
    access(1'b1, 1'b1, 17'h1FFFF, 16'hC3D4, 1'b0);
    check("plan_wrap_ram", 64'(ram[0][7:0]), 64'(8'hC3));
    access(1'b0, 1'b1, 17'h1FFFF, 16'h0000, 1'b0);
    check("plan_wrap", 64'(bus.rdata), 64'(16'hC3D4));
    access(1'b1, 1'b1, 17'h00040, 16'h1357, 1'b1);
    access(1'b0, 1'b1, 17'h00040, 16'h0000, 1'b0);
    check("plan_hold", 64'(bus.rdata), 64'(16'h1357));
    // Abort a split read while its first lane is waiting for data
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.word = 1'b1; bus.cpu_addr = 17'h00031;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async", {bus.ack, bus.rdata, bus.mem_cs, bus.mem_oe, bus.mem_wr, bus.mem_even,
                          bus.mem_odd, bus.mem_addr, bus.mem_din}, 64'(0));
    bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.ack) seen = 1'b1;
    end
    check("no_ack_after_abort", 64'(seen), 64'(0));
    last_rdata = 16'h0000;
    access(1'b0, 1'b0, 17'h00032, 16'h0000, 1'b0);
    check("plan_after_reset", 64'(bus.rdata), 64'(16'h00A5));
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 1) ? 17'h1FFC0 : 17'h00100) + 17'($urandom_range(0, 127));
      access(1'($urandom), 1'($urandom), ra, 16'($urandom), $urandom_range(0, 3) == 0);
    end
    @(negedge clk); bus.req = 1'b0;
    repeat (8) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
